// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_controller
//  Purpose  : Pipeline sequencing controller placed next to the forwarding
//             unit. It handles the hazards that forwarding cannot cover:
//             load-use stalls (stall plus bubble), multi-cycle data-memory
//             freezes, and taken-branch flushes. It also keeps a saturating
//             count of the cycles in which the PC was held.
//  Ports    : clk, rst_n (sync, active-low)
//             id_*        - register usage of the instruction in ID
//             ex_*        - validity, load flag and destination of EX instr
//             branch_taken, mem_req, mem_ready - events from EX / MEM
//             pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_en,
//             id_ex_bubble, ex_mem_en, mem_wb_bubble - pipeline controls
//             state, stall_count - debug / performance observation
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_controller #(
    parameter int REG_ADDR_W   = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  id_src,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   id_uses_src,
    input  logic                   id_uses_dest,
    input  logic                   ex_valid,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_dest,
    input  logic                   branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   pc_sel_target,
    output logic                   if_id_en,
    output logic                   if_id_flush,
    output logic                   id_ex_en,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_en,
    output logic                   mem_wb_bubble,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Counter holds at most FLUSH_CYCLES-1 (<= 3), so two bits suffice.
    localparam logic [1:0] FLUSH_INIT  = 2'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t     cur_state;
    state_t     nxt_state;
    logic [1:0] flush_cnt;
    logic [1:0] nxt_flush_cnt;
    logic       pending;
    logic       nxt_pending;

    logic       load_use;
    logic       freeze;

    assign load_use = ex_valid & ex_mem_read &
                      ((id_uses_src  & (id_src  == ex_dest)) |
                       (id_uses_dest & (id_dest == ex_dest)));

    // In MEM_WAIT the freeze is released only by mem_ready; elsewhere a
    // new access that is not immediately ready starts the freeze.
    assign freeze = (cur_state == MEM_WAIT) ? ~mem_ready : (mem_req & ~mem_ready);

    assign state = cur_state;

    always_comb begin
        pc_en         = 1'b1;
        pc_sel_target = 1'b0;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        nxt_state     = cur_state;
        nxt_flush_cnt = flush_cnt;
        nxt_pending   = pending;

        // While in reset the outputs keep the RUN/no-hazard defaults.
        if (rst_n) begin
            if (freeze) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_bubble = 1'b1;
                nxt_state     = MEM_WAIT;
                // A branch seen while frozen is replayed in the ready cycle.
                nxt_pending   = pending | branch_taken;
            end else if (branch_taken | pending) begin
                // Load-use stall is irrelevant: the ID instruction is squashed.
                pc_sel_target = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                nxt_pending   = 1'b0;
                if (MULTI_FLUSH) begin
                    nxt_state     = FLUSH;
                    nxt_flush_cnt = FLUSH_INIT;
                end else begin
                    nxt_state     = RUN;
                    nxt_flush_cnt = 2'd0;
                end
            end else if (cur_state == FLUSH) begin
                if_id_flush = 1'b1;
                if (flush_cnt <= 2'd1) begin
                    nxt_state     = RUN;
                    nxt_flush_cnt = 2'd0;
                end else begin
                    nxt_flush_cnt = flush_cnt - 2'd1;
                end
            end else begin
                // RUN, or the mem_ready cycle of MEM_WAIT with no branch.
                nxt_state = RUN;
                if (load_use) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state   <= RUN;
            flush_cnt   <= 2'd0;
            pending     <= 1'b0;
            stall_count <= '0;
        end else begin
            cur_state <= nxt_state;
            flush_cnt <= nxt_flush_cnt;
            pending   <= nxt_pending;
            if (!pc_en && (stall_count != {STALL_CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller that sits beside the forwarding logic, between the ID/EX and EX/MEM pipeline registers.
- Resolves the hazards that forwarding cannot resolve:
  - load-use data hazards, by inserting a stall and a bubble;
  - multi-cycle data-memory accesses, by freezing the pipeline;
  - taken branches resolved in EX, by flushing IF/ID and ID/EX.
- Drives the pipeline-register enables, the flush and bubble controls, and the PC enable/select, and keeps a saturating stall counter for performance debug.

Parameters:
- REG_ADDR_W, 4, register-address width; matches the forwarding source/destination fields.
- FLUSH_CYCLES, 1, number of cycles the flush is asserted after a taken branch; legal range 1..4.
- STALL_CNT_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- id_src  in  REG_ADDR_W  source register of the instruction in ID.
- id_dest  in  REG_ADDR_W  second (dest-as-source) register read by the instruction in ID.
- id_uses_src  in  1  ID instruction reads id_src.
- id_uses_dest  in  1  ID instruction reads id_dest.
- ex_valid  in  1  EX stage holds a real instruction (0 = bubble).
- ex_mem_read  in  1  EX instruction is a memory load.
- ex_dest  in  REG_ADDR_W  destination register of the EX instruction.
- branch_taken  in  1  branch in EX resolved as taken (single-cycle pulse).
- mem_req  in  1  MEM stage is performing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- pc_sel_target  out  1  PC loads the branch target instead of PC+1.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  clears IF/ID to a bubble.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_bubble  out  1  loads a bubble into ID/EX.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_bubble  out  1  loads a bubble into MEM/WB.
- state  out  2  FSM state, for debug.
- stall_count  out  STALL_CNT_W  saturating count of cycles in which pc_en = 0.

Behaviour:
- **Reset.** Registers clear on the clk edge where rst_n = 0.
  - State values: RUN = 0, MEM_WAIT = 1, FLUSH = 2.
  - Reset state: state = RUN, flush counter = 0, pending-branch flag = 0, stall_count = 0.
  - During reset, outputs take the RUN/no-hazard values.
  - Reset asserted mid-MEM_WAIT or mid-FLUSH abandons the operation and drops any pending branch.
- **Output style.** Control outputs are Mealy (combinational from state and inputs); state and counters are registered.
- **Default outputs (RUN, no event):**
  - pc_en = if_id_en = id_ex_en = ex_mem_en = 1.
  - All flush, bubble and select outputs = 0.
- **Load-use hazard (RUN).** Detected when ex_valid & ex_mem_read & ((id_uses_src & id_src == ex_dest) | (id_uses_dest & id_dest == ex_dest)).
  - Same-cycle response: pc_en = 0, if_id_en = 0, id_ex_bubble = 1.
  - State stays RUN; exactly a 1-cycle stall.
  - The next cycle the load is in MEM and the forwarding unit resolves the dependency.
- **Memory wait.** Triggered when mem_req & !mem_ready in RUN or FLUSH.
  - Freeze for that cycle and every following cycle: pc_en = if_id_en = id_ex_en = ex_mem_en = 0, mem_wb_bubble = 1.
  - Next state is MEM_WAIT.
  - In MEM_WAIT the freeze holds until the cycle in which mem_ready = 1. That cycle uses the normal RUN output rules (including hazard rules); the next state is RUN, or FLUSH if a branch was pending.
  - mem_req & mem_ready in the same cycle is a zero-wait access: no freeze.
- **Taken branch (RUN).** Response in the branch_taken cycle:
  - pc_en = 1, pc_sel_target = 1, if_id_flush = 1, id_ex_bubble = 1.
  - The load-use stall is suppressed, because the ID instruction is squashed.
  - If FLUSH_CYCLES > 1: enter FLUSH with the counter at FLUSH_CYCLES-1.
  - FLUSH asserts if_id_flush = 1 each cycle and decrements the counter, returning to RUN when the counter reaches 1.
- **Branch and memory wait coinciding.**
  - branch_taken together with mem_req & !mem_ready: the freeze wins.
  - The branch is latched as pending and applied (target select plus flushes) in the mem_ready cycle.
  - branch_taken asserted while already in MEM_WAIT is latched the same way.
- **Priority:** reset > memory freeze > taken branch > load-use > normal.
- **Stall counter.** stall_count increments on every cycle with pc_en = 0 and saturates at all-ones.
- **Hazard-check scope.** A register match where ex_valid = 0 is never a hazard.

Test Plan:
- rst_n = 0 for 2 cycles during MEM_WAIT, then rst_n = 1 -> state = 0, stall_count = 0, pc_en = 1; the pending branch is discarded.
- ex_valid = 1, ex_mem_read = 1, ex_dest = 5, id_src = 5, id_uses_src = 1 -> that cycle pc_en = 0, if_id_en = 0, id_ex_bubble = 1; the next cycle (load moved on) pc_en = 1; stall_count = 1.
- Same as the previous case but id_uses_src = 0, or ex_valid = 0 -> no stall; all enables = 1.
- mem_req = 1 with mem_ready low for 3 cycles, then high -> 3 cycles frozen (ex_mem_en = 0, mem_wb_bubble = 1, state = 1); the 4th cycle has enables = 1; stall_count = 3.
- branch_taken together with mem_req = 1, mem_ready = 0, ready after 2 cycles, FLUSH_CYCLES = 1:
  - pc_sel_target = 0 while frozen;
  - in the ready cycle pc_sel_target = 1, if_id_flush = 1, id_ex_bubble = 1;
  - state = RUN afterwards.
- FLUSH_CYCLES = 3, branch_taken coinciding with a load-use match -> no stall; if_id_flush = 1 for 3 consecutive cycles; state = 2 for 2 cycles, then RUN.
